rr_mux16_scheduler: RTL and testbench

Round-robin scheduler that shares the 16:1 single-bit mux datapath between 16 requesters. Each cycle it arbitrates among enabled requesters and drives the mux select with the winner's index. It registers the selected data bit and offers it downstream on a valid/ready handshake. It sits between the requester bank and the serial consumer, and is the only driver of the mux select.

---
 rtl/rr_mux16_scheduler_pkg.sv | 21 ++
 rtl/rr_mux16_scheduler_if.sv | 27 ++
 rtl/rr_mux16_scheduler_mux16to1.sv | 12 +
 rtl/rr_mux16_scheduler.sv | 114 +++++++++++
 tb/tb_rr_mux16_scheduler.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rr_mux16_scheduler_pkg.sv
// rtl/rr_mux16_scheduler_pkg.sv - shared constants, state encoding and helpers for the scheduler
package rr_mux16_scheduler_pkg;

  localparam int N  = 16;
  localparam int SW = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    HOLD   = 2'd2
  } state_e;

  // One-hot vector with only bit idx set.
  function automatic logic [N-1:0] onehot(input logic [SW-1:0] idx);
    logic [N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_mux16_scheduler_if.sv
// rtl/rr_mux16_scheduler_if.sv - requester bank / consumer bundle around the scheduler
interface rr_mux16_scheduler_if;
  import rr_mux16_scheduler_pkg::*;

  logic [N-1:0]  req;
  logic [N-1:0]  en_mask;
  logic [N-1:0]  w;
  logic          ready;
  logic [N-1:0]  gnt;
  logic [SW-1:0] s;
  logic          f;
  logic          valid;
  logic          busy;

  // Requester bank and downstream consumer side.
  modport master (
    output req, en_mask, w, ready,
    input  gnt, s, f, valid, busy
  );

  // Scheduler side.
  modport slave (
    input  req, en_mask, w, ready,
    output gnt, s, f, valid, busy
  );

endinterface

// File: rtl/rr_mux16_scheduler_mux16to1.sv
// rtl/rr_mux16_scheduler_mux16to1.sv - shared 16:1 single-bit mux datapath
module mux16to1
  import rr_mux16_scheduler_pkg::*;
(
  input  logic [N-1:0]  w,
  input  logic [SW-1:0] s,
  output logic          y
);

  assign y = w[s];

endmodule

// File: rtl/rr_mux16_scheduler.sv
// rtl/rr_mux16_scheduler.sv - round-robin owner of the 16:1 mux select with registered valid/ready output
module rr_mux16_scheduler
  import rr_mux16_scheduler_pkg::*;
(
  input  logic                 clk,
  input  logic                 resetn,
  rr_mux16_scheduler_if.slave  bus
);

  state_e        state_q, state_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic [SW-1:0] s_q, s_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic          f_q, f_d;
  logic          valid_q, valid_d;

  logic [N-1:0]  elig;
  logic [N-1:0]  rot;
  logic [SW-1:0] first;
  logic [SW-1:0] winner;
  logic          mux_bit;

  assign elig = bus.req & bus.en_mask;

  // Rotate eligibility so ptr sits at bit 0, pick the lowest set bit, then rotate the index back.
  always_comb begin
    rot   = '0;
    first = '0;
    for (int j = 0; j < N; j++) begin
      rot[j] = elig[SW'(j) + ptr_q];
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        first = SW'(i);
      end
    end
    winner = first + ptr_q;
  end

  mux16to1 u_mux (
    .w (bus.w),
    .s (s_q),
    .y (mux_bit)
  );

  // State and datapath registers; reset abandons any transfer in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      s_q     <= '0;
      gnt_q   <= '0;
      f_q     <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      s_q     <= s_d;
      gnt_q   <= gnt_d;
      f_q     <= f_d;
      valid_q <= valid_d;
    end
  end

  // Next-state logic: arbitrate in IDLE, capture the mux bit in SAMPLE, wait for ready in HOLD.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    s_d     = s_q;
    gnt_d   = gnt_q;
    f_d     = f_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (|elig) begin
          s_d     = winner;
          gnt_d   = onehot(winner);
          state_d = SAMPLE;
        end else begin
          s_d   = '0;
          gnt_d = '0;
        end
      end
      SAMPLE: begin
        f_d     = mux_bit;
        valid_d = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (bus.ready) begin
          valid_d = 1'b0;
          gnt_d   = '0;
          s_d     = '0;
          ptr_d   = s_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        gnt_d   = '0;
        s_d     = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign bus.gnt   = gnt_q;
  assign bus.s     = s_q;
  assign bus.f     = f_q;
  assign bus.valid = valid_q;
  assign bus.busy  = (state_q != IDLE);

endmodule

// File: tb/tb_rr_mux16_scheduler.sv
// tb/tb_rr_mux16_scheduler.sv - self-checking bench for rr_mux16_scheduler
module tb_rr_mux16_scheduler;
  import rr_mux16_scheduler_pkg::*;

  logic clk = 1'b0;
  logic resetn;

  always #5 clk = ~clk;

  rr_mux16_scheduler_if bus ();

  rr_mux16_scheduler dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [3:0] s;
    logic       f;
  } exp_t;

  typedef struct {
    logic [15:0] req;
    logic [15:0] en;
    logic [15:0] w;
    logic [3:0]  s;
    logic        f;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] oh(input logic [3:0] i);
    logic [15:0] v;
    v    = 16'h0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic wait_valid(input string name);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (bus.valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check({name, " valid_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic pop_compare(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      check({name, " scoreboard_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check({name, " s"}, 32'(bus.s), 32'(e.s));
    check({name, " f"}, 32'(bus.f), 32'(e.f));
    check({name, " gnt"}, 32'(bus.gnt), 32'(oh(e.s)));
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn      = 1'b0;
    bus.req     = '0;
    bus.en_mask = 16'hFFFF;
    bus.w       = '0;
    bus.ready   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'h0008, 16'hFFFF, 16'h0008, 4'd3,  1'b1};
    vecs[1] = '{16'h0008, 16'hFFFF, 16'h0000, 4'd3,  1'b0};
    vecs[2] = '{16'h0011, 16'hFFFF, 16'hFFFF, 4'd4,  1'b1};
    vecs[3] = '{16'h0011, 16'hFFEF, 16'h0001, 4'd0,  1'b1};
    vecs[4] = '{16'h8000, 16'hFFFF, 16'h7FFF, 4'd15, 1'b0};
    vecs[5] = '{16'hA000, 16'hFFFF, 16'h2000, 4'd13, 1'b1};
    vecs[6] = '{16'hC003, 16'h7FFF, 16'h4000, 4'd14, 1'b1};
    vecs[7] = '{16'hC003, 16'h7FFF, 16'h0000, 4'd0,  1'b0};
    vecs[8] = '{16'hC003, 16'h7FFF, 16'h0002, 4'd1,  1'b1};
    vecs[9] = '{16'hC003, 16'h7FFF, 16'h0000, 4'd14, 1'b0};

    resetn      = 1'b0;
    bus.req     = '0;
    bus.en_mask = 16'hFFFF;
    bus.w       = '0;
    bus.ready   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset gnt",   32'(bus.gnt),   32'd0);
    check("reset s",     32'(bus.s),     32'd0);
    check("reset f",     32'(bus.f),     32'd0);
    check("reset valid", 32'(bus.valid), 32'd0);
    check("reset busy",  32'(bus.busy),  32'd0);
    resetn = 1'b1;

    // Single persistent requester: valid every third cycle.
    @(negedge clk);
    bus.req     = 16'h0008;
    bus.en_mask = 16'hFFFF;
    bus.w       = 16'h0008;
    bus.ready   = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      if (n == 1) begin
        check("single grant s",   32'(bus.s),   32'd3);
        check("single grant gnt", 32'(bus.gnt), 32'h0008);
      end
      check($sformatf("single valid cycle %0d", n), 32'(bus.valid), (n % 3 == 2) ? 32'd1 : 32'd0);
      if (n == 2) check("single f", 32'(bus.f), 32'd1);
    end
    bus.req = '0;

    // Table of single transfers from ptr=0, including wrap and masking.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      bus.req     = vecs[i].req;
      bus.en_mask = vecs[i].en;
      bus.w       = vecs[i].w;
      bus.ready   = 1'b1;
      sb.push_back('{s: vecs[i].s, f: vecs[i].f});
      @(negedge clk);
      check($sformatf("vec%0d grant s", i),   32'(bus.s),     32'(vecs[i].s));
      check($sformatf("vec%0d grant gnt", i), 32'(bus.gnt),   32'(oh(vecs[i].s)));
      check($sformatf("vec%0d busy", i),      32'(bus.busy),  32'd1);
      check($sformatf("vec%0d early valid", i), 32'(bus.valid), 32'd0);
      bus.req     = '0;
      bus.en_mask = '0;
      wait_valid($sformatf("vec%0d", i));
      pop_compare($sformatf("vec%0d", i));
      @(negedge clk);
      check($sformatf("vec%0d idle valid", i), 32'(bus.valid), 32'd0);
      check($sformatf("vec%0d idle busy", i),  32'(bus.busy),  32'd0);
      check($sformatf("vec%0d idle gnt", i),   32'(bus.gnt),   32'd0);
      check($sformatf("vec%0d idle s", i),     32'(bus.s),     32'd0);
    end

    // Fairness: all requesters eligible, grants sweep 0..15 then 0.
    do_reset();
    bus.req     = 16'hFFFF;
    bus.en_mask = 16'hFFFF;
    bus.w       = 16'hAAAA;
    bus.ready   = 1'b1;
    for (int t = 0; t < 17; t++) begin
      sb.push_back('{s: 4'(t % 16), f: ((t % 2) == 1)});
    end
    for (int t = 0; t < 17; t++) begin
      wait_valid($sformatf("rr%0d", t));
      pop_compare($sformatf("rr%0d", t));
      @(negedge clk);
      if (t == 16) bus.req = '0;
    end
    @(negedge clk);

    // Backpressure: hold for five cycles, request drop ignored, then accept.
    do_reset();
    bus.req     = 16'h0100;
    bus.en_mask = 16'hFFFF;
    bus.w       = 16'h0100;
    bus.ready   = 1'b0;
    sb.push_back('{s: 4'd8, f: 1'b1});
    wait_valid("bp");
    pop_compare("bp");
    for (int h = 0; h < 5; h++) begin
      if (h == 1) bus.req = '0;
      @(negedge clk);
      check($sformatf("bp hold%0d valid", h), 32'(bus.valid), 32'd1);
      check($sformatf("bp hold%0d f", h),     32'(bus.f),     32'd1);
      check($sformatf("bp hold%0d s", h),     32'(bus.s),     32'd8);
      check($sformatf("bp hold%0d gnt", h),   32'(bus.gnt),   32'h0100);
    end
    bus.ready = 1'b1;
    @(negedge clk);
    check("bp release valid", 32'(bus.valid), 32'd0);
    check("bp release busy",  32'(bus.busy),  32'd0);
    check("bp release gnt",   32'(bus.gnt),   32'd0);

    // Reset asserted mid-HOLD clears outputs at once and restarts from ptr=0.
    bus.req   = 16'h0010;
    bus.w     = 16'h0010;
    bus.ready = 1'b0;
    sb.push_back('{s: 4'd4, f: 1'b1});
    wait_valid("rst_hold");
    pop_compare("rst_hold");
    #2;
    resetn = 1'b0;
    #1;
    check("rst_hold gnt",   32'(bus.gnt),   32'd0);
    check("rst_hold s",     32'(bus.s),     32'd0);
    check("rst_hold f",     32'(bus.f),     32'd0);
    check("rst_hold valid", 32'(bus.valid), 32'd0);
    check("rst_hold busy",  32'(bus.busy),  32'd0);
    bus.req = '0;
    @(negedge clk);
    resetn = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check($sformatf("post_rst quiet%0d valid", n), 32'(bus.valid), 32'd0);
    end
    bus.req   = 16'h0011;
    bus.w     = 16'h0001;
    bus.ready = 1'b1;
    sb.push_back('{s: 4'd0, f: 1'b1});
    @(negedge clk);
    check("post_rst grant s", 32'(bus.s), 32'd0);
    bus.req = '0;
    wait_valid("post_rst");
    pop_compare("post_rst");
    @(negedge clk);
    check("post_rst idle valid", 32'(bus.valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
